// File: rtl/conv_1x1_mac_engine_pkg.sv
// Shared definitions for the 1x1 convolution MAC engine: FSM encoding,
// pipeline depth and counter-width helper.
package conv_1x1_mac_engine_pkg;

    typedef enum logic [1:0] {
        S_LOAD_W = 2'd0,
        S_FILL   = 2'd1,
        S_MAC    = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    // Read, multiply, accumulate.
    localparam int MAC_LATENCY = 3;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_1x1_mac_engine_mac_unit.sv
// Multiply/accumulate datapath: product register, accumulator, and the
// round/saturate/ReLU output register with its valid/last tracking.
module conv_1x1_mac_unit
    import conv_1x1_mac_engine_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int ACC_WIDTH  = 40,
    parameter int RELU_EN    = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic                         in_first,
    input  logic                         in_last_ic,
    input  logic                         in_last_oc,
    input  logic signed [DATA_WIDTH-1:0] in_weight,
    input  logic signed [DATA_WIDTH-1:0] in_pixel,
    output logic [DATA_WIDTH-1:0]        pxl_out,
    output logic                         valid_out,
    output logic                         last_out
);

    localparam int PW      = 2 * DATA_WIDTH;
    localparam int SW      = ACC_WIDTH + 1;
    localparam int RND_INT = (FRAC_BITS > 0) ? (1 << (FRAC_BITS - 1)) : 0;

    logic signed [PW-1:0]        prod;
    logic signed [ACC_WIDTH-1:0] prod_ext;
    logic signed [ACC_WIDTH-1:0] acc;
    logic                        v2, f2, li2, lo2;
    logic                        v3, lo3;

    logic signed [SW-1:0]        acc_ext;
    logic signed [SW-1:0]        rounded;
    logic signed [SW-1:0]        shifted;
    logic                        fits;
    logic [DATA_WIDTH-1:0]       sat;
    logic [DATA_WIDTH-1:0]       res;

    always_ff @(posedge clk) begin
        prod <= in_weight * in_pixel;
        if (v2) begin
            acc <= f2 ? prod_ext : acc + prod_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v2        <= 1'b0;
            f2        <= 1'b0;
            li2       <= 1'b0;
            lo2       <= 1'b0;
            v3        <= 1'b0;
            lo3       <= 1'b0;
            valid_out <= 1'b0;
            last_out  <= 1'b0;
            pxl_out   <= '0;
        end else begin
            v2        <= in_valid;
            f2        <= in_first;
            li2       <= in_last_ic;
            lo2       <= in_last_oc;
            v3        <= v2 && li2;
            lo3       <= lo2;
            valid_out <= v3;
            last_out  <= v3 && lo3;
            if (v3) begin
                pxl_out <= res;
            end
        end
    end

    // One extra bit keeps the rounding addend from wrapping the accumulator.
    always_comb begin
        prod_ext = {{(ACC_WIDTH - PW){prod[PW-1]}}, prod};
        acc_ext  = {acc[ACC_WIDTH-1], acc};
        rounded  = acc_ext + SW'(RND_INT);
        shifted  = rounded >>> FRAC_BITS;
        fits     = (shifted[SW-1:DATA_WIDTH-1] == {(SW - DATA_WIDTH + 1){shifted[SW-1]}});
        if (fits) begin
            sat = shifted[DATA_WIDTH-1:0];
        end else if (shifted[SW-1]) begin
            sat = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
        end else begin
            sat = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
        end
        res = ((RELU_EN != 0) && sat[DATA_WIDTH-1]) ? '0 : sat;
    end

endmodule

// File: rtl/conv_1x1_mac_engine.sv
// 1x1 convolution engine: resident CH_OUT x CH_IN weight set, per-pixel
// channel buffer, and a sequencer issuing one MAC per cycle.
module conv_1x1_mac_engine
    import conv_1x1_mac_engine_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int CH_IN      = 256,
    parameter int CH_OUT     = 256,
    parameter int RELU_EN    = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    output logic                  ready_in,
    input  logic                  valid_weight_in,
    input  logic [DATA_WIDTH-1:0] weight_in,
    output logic                  ready_weight,
    input  logic                  weight_reload,
    output logic [DATA_WIDTH-1:0] pxl_out,
    output logic                  valid_out,
    output logic                  last_out,
    output logic                  weights_loaded,
    output state_t                fsm_state
);

    localparam int WTOTAL     = CH_OUT * CH_IN;
    localparam int ACC_WIDTH  = 2 * DATA_WIDTH + $clog2(CH_IN);
    localparam int WCNT_WIDTH = cnt_width(WTOTAL);
    localparam int ICNT_WIDTH = cnt_width(CH_IN);
    localparam int OCNT_WIDTH = cnt_width(CH_OUT);
    localparam int DCNT_WIDTH = cnt_width(MAC_LATENCY);

    state_t                  state, state_nxt;
    logic [WCNT_WIDTH-1:0]   wcnt;
    logic [WCNT_WIDTH-1:0]   maddr;
    logic [ICNT_WIDTH-1:0]   icnt;
    logic [OCNT_WIDTH-1:0]   ocnt;
    logic [DCNT_WIDTH-1:0]   dcnt;
    logic                    loaded;

    logic                    w_fire, p_fire, reload_req, issue;
    logic                    w_last, ic_last, oc_last, d_last;

    logic [DATA_WIDTH-1:0]   wram [WTOTAL];
    logic [DATA_WIDTH-1:0]   pbuf [CH_IN];
    logic [DATA_WIDTH-1:0]   rd_w, rd_p;
    logic                    p1_valid, p1_first, p1_last_ic, p1_last_oc;

    assign weights_loaded = loaded;
    assign fsm_state      = state;

    always_comb begin
        w_last  = (wcnt == WCNT_WIDTH'(WTOTAL - 1));
        ic_last = (icnt == ICNT_WIDTH'(CH_IN - 1));
        oc_last = (ocnt == OCNT_WIDTH'(CH_OUT - 1));
        d_last  = (dcnt == DCNT_WIDTH'(MAC_LATENCY - 1));
    end

    // Handshake: a word moves only in a cycle where valid and ready are both
    // high; ready depends on state alone, except that a honoured reload
    // request takes precedence over a pixel offered in the same cycle.
    always_comb begin
        state_nxt    = state;
        ready_weight = 1'b0;
        ready_in     = 1'b0;
        reload_req   = 1'b0;
        issue        = 1'b0;
        w_fire       = 1'b0;
        p_fire       = 1'b0;
        case (state)
            S_LOAD_W: begin
                ready_weight = 1'b1;
                w_fire       = valid_weight_in;
                if (w_fire && w_last) begin
                    state_nxt = S_FILL;
                end
            end
            S_FILL: begin
                reload_req = weight_reload && (icnt == '0);
                ready_in   = !reload_req;
                p_fire     = valid_in && ready_in;
                if (reload_req) begin
                    state_nxt = S_LOAD_W;
                end else if (p_fire && ic_last) begin
                    state_nxt = S_MAC;
                end
            end
            S_MAC: begin
                issue = 1'b1;
                if (ic_last && oc_last) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (d_last) begin
                    state_nxt = S_FILL;
                end
            end
            default: state_nxt = S_LOAD_W;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_LOAD_W;
        end else begin
            state <= state_nxt;
        end
    end

    // icnt doubles as the fill index and the MAC inner-loop index.
    always_ff @(posedge clk) begin
        if (reset) begin
            wcnt   <= '0;
            icnt   <= '0;
            ocnt   <= '0;
            maddr  <= '0;
            dcnt   <= '0;
            loaded <= 1'b0;
        end else begin
            case (state)
                S_LOAD_W: begin
                    if (w_fire) begin
                        wcnt <= w_last ? '0 : wcnt + 1'b1;
                        if (w_last) begin
                            loaded <= 1'b1;
                        end
                    end
                end
                S_FILL: begin
                    if (reload_req) begin
                        loaded <= 1'b0;
                        wcnt   <= '0;
                    end else if (p_fire) begin
                        icnt <= ic_last ? '0 : icnt + 1'b1;
                    end
                end
                S_MAC: begin
                    icnt  <= ic_last ? '0 : icnt + 1'b1;
                    maddr <= (ic_last && oc_last) ? '0 : maddr + 1'b1;
                    if (ic_last) begin
                        ocnt <= oc_last ? '0 : ocnt + 1'b1;
                    end
                end
                S_DRAIN: begin
                    dcnt <= d_last ? '0 : dcnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_fire) begin
            wram[wcnt] <= weight_in;
        end
        if (p_fire) begin
            pbuf[icnt] <= pxl_in;
        end
        rd_w <= wram[maddr];
        rd_p <= pbuf[icnt];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            p1_valid   <= 1'b0;
            p1_first   <= 1'b0;
            p1_last_ic <= 1'b0;
            p1_last_oc <= 1'b0;
        end else begin
            p1_valid   <= issue;
            p1_first   <= issue && (icnt == '0);
            p1_last_ic <= issue && ic_last;
            p1_last_oc <= issue && oc_last;
        end
    end

    conv_1x1_mac_unit #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (FRAC_BITS),
        .ACC_WIDTH  (ACC_WIDTH),
        .RELU_EN    (RELU_EN)
    ) u_mac (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (p1_valid),
        .in_first   (p1_first),
        .in_last_ic (p1_last_ic),
        .in_last_oc (p1_last_oc),
        .in_weight  (rd_w),
        .in_pixel   (rd_p),
        .pxl_out    (pxl_out),
        .valid_out  (valid_out),
        .last_out   (last_out)
    );

endmodule
